// File: rtl/eth_tx_noc_in_deframe.sv
// eth_tx_noc_in_deframe: NoC-side ingress of the Ethernet TX tile (header, metadata, body flits -> hdr + payload beats).
// Optional frame checks (msg_len vs data_size, destination coords, sticky error) enabled by ETH_TX_NOC_IN_CHECK_EN.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif
module eth_tx_noc_in_deframe #(
  parameter int SRC_X = -1,
  parameter int SRC_Y = -1,
  parameter int ETH_HDR_W = 112
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          noc0_ctovr_eth_tx_in_val,
  input  logic [`NOC_DATA_WIDTH-1:0]    noc0_ctovr_eth_tx_in_data,
  output logic                          eth_tx_in_noc0_ctovr_rdy,
  output logic                          eth_tx_in_eth_format_hdr_val,
  output logic [ETH_HDR_W-1:0]          eth_tx_in_eth_format_eth_hdr,
  output logic [`MTU_SIZE_W-1:0]        eth_tx_in_eth_format_data_size,
  input  logic                          eth_format_eth_tx_in_hdr_rdy,
  output logic                          eth_tx_in_eth_format_data_val,
  output logic [`MAC_INTERFACE_W-1:0]   eth_tx_in_eth_format_data,
  output logic                          eth_tx_in_eth_format_data_last,
  output logic [`MAC_PADBYTES_W-1:0]    eth_tx_in_eth_format_data_padbytes,
  input  logic                          eth_format_eth_tx_in_data_rdy,
  output logic                          eth_tx_in_err
);
  localparam int W = `NOC_DATA_WIDTH;
  localparam int B = `MAC_INTERFACE_W / 8;
  localparam logic [2:0] RD_HDR = 3'd0, RD_META = 3'd1, HDR_OUT = 3'd2, DATA = 3'd3, DROP = 3'd4;
  logic [2:0] state;
  logic [7:0] msg_len, count, dst_x, dst_y;
  logic [ETH_HDR_W-1:0] eth_hdr;
  logic [`MTU_SIZE_W-1:0] data_size;
  logic [7:0] h_dst_x, h_dst_y, h_len;
  logic [ETH_HDR_W-1:0] m_hdr;
  logic [`MTU_SIZE_W-1:0] m_size;
  logic in_val, rdy, fire, last, bad, err_set;
  // Header flit: {dst_x, dst_y, msg_len, ...}; metadata flit: {eth_hdr, data_size, ...}, both MSB-first
  assign h_dst_x = noc0_ctovr_eth_tx_in_data[W-1 -: 8];
  assign h_dst_y = noc0_ctovr_eth_tx_in_data[W-9 -: 8];
  assign h_len   = noc0_ctovr_eth_tx_in_data[W-17 -: 8];
  assign m_hdr   = noc0_ctovr_eth_tx_in_data[W-1 -: ETH_HDR_W];
  assign m_size  = noc0_ctovr_eth_tx_in_data[W-ETH_HDR_W-1 -: `MTU_SIZE_W];
  assign in_val = noc0_ctovr_eth_tx_in_val & ~rst;
  always_comb begin
    rdy = (state == RD_HDR || state == RD_META || state == DROP) ? 1'b1 :
          (state == DATA) ? eth_format_eth_tx_in_data_rdy : 1'b0;
    rdy = rdy & ~rst;
  end
  assign fire = in_val & rdy;
  assign last = ~rst & (state == DATA) & (count == 8'd1);
  assign eth_tx_in_noc0_ctovr_rdy = rdy;
  assign eth_tx_in_eth_format_hdr_val = ~rst & (state == HDR_OUT);
  assign eth_tx_in_eth_format_eth_hdr = eth_hdr;
  assign eth_tx_in_eth_format_data_size = data_size;
  assign eth_tx_in_eth_format_data_val = in_val & (state == DATA);
  assign eth_tx_in_eth_format_data = noc0_ctovr_eth_tx_in_data;
  assign eth_tx_in_eth_format_data_last = last;
  assign eth_tx_in_eth_format_data_padbytes =
    last ? `MAC_PADBYTES_W'((B - int'(data_size) % B) % B) : '0;
`ifdef ETH_TX_NOC_IN_CHECK_EN
  assign bad = (int'(msg_len) - 1 != (int'(m_size) + B - 1) / B) ||
               dst_x != 8'(SRC_X) || dst_y != 8'(SRC_Y);
  assign err_set = fire & ((state == RD_HDR && h_len == 8'd0) || (state == RD_META && bad));
  always_ff @(posedge clk)
    if (rst) eth_tx_in_err <= 1'b0;
    else if (err_set) eth_tx_in_err <= 1'b1;
`else
  logic unused_ok;
  assign bad = 1'b0;
  assign err_set = 1'b0;
  assign unused_ok = ^{dst_x, dst_y, 8'(SRC_X), 8'(SRC_Y), err_set};
  assign eth_tx_in_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= RD_HDR;
      count <= '0;
    end else
      case (state)
        RD_HDR: if (fire) begin
          msg_len <= h_len;
          dst_x <= h_dst_x;
          dst_y <= h_dst_y;
          state <= (h_len == 8'd0) ? RD_HDR : RD_META;
        end
        RD_META: if (fire) begin
          eth_hdr <= m_hdr;
          data_size <= m_size;
          count <= msg_len - 8'd1;
          state <= !bad ? HDR_OUT : (msg_len == 8'd1) ? RD_HDR : DROP;
        end
        HDR_OUT: if (eth_format_eth_tx_in_hdr_rdy) state <= (count != 8'd0) ? DATA : RD_HDR;
        DATA, DROP: if (fire) begin
          count <= count - 8'd1;
          if (count == 8'd1) state <= RD_HDR;
        end
        default: state <= RD_HDR;
      endcase
endmodule

// File: tb/tb_eth_tx_noc_in_deframe.sv
// tb_eth_tx_noc_in_deframe: directed and stall-randomised frames checked against an expected-output scoreboard.
module tb_eth_tx_noc_in_deframe;
  logic clk = 0, rst = 1;
  logic in_val = 0;
  logic [511:0] in_data = '0;
  logic in_rdy, hdr_val, hdr_rdy = 1, data_val, data_rdy = 1, last, err;
  logic [111:0] eth_hdr;
  logic [15:0] size;
  logic [511:0] data;
  logic [5:0] pad;
  int vectors = 0, miscompares = 0;
  int hdrs = 0, beats = 0, last_pad = -1;
  bit stall = 0;
  logic [127:0] exp_hdr[$];
  logic [518:0] exp_beat[$];
  logic p_hv, p_hr, p_dv, p_dr;
  logic [127:0] p_h;
  logic [511:0] p_d;

  eth_tx_noc_in_deframe #(.SRC_X(3), .SRC_Y(5)) dut (
    .clk(clk), .rst(rst),
    .noc0_ctovr_eth_tx_in_val(in_val), .noc0_ctovr_eth_tx_in_data(in_data),
    .eth_tx_in_noc0_ctovr_rdy(in_rdy),
    .eth_tx_in_eth_format_hdr_val(hdr_val), .eth_tx_in_eth_format_eth_hdr(eth_hdr),
    .eth_tx_in_eth_format_data_size(size), .eth_format_eth_tx_in_hdr_rdy(hdr_rdy),
    .eth_tx_in_eth_format_data_val(data_val), .eth_tx_in_eth_format_data(data),
    .eth_tx_in_eth_format_data_last(last), .eth_tx_in_eth_format_data_padbytes(pad),
    .eth_format_eth_tx_in_data_rdy(data_rdy), .eth_tx_in_err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] beat(input int f, input int i);
    return {16{f[15:0], i[15:0]}};
  endfunction

  function automatic logic [111:0] ehdr(input int f);
    return {7{f[15:0] ^ 16'hA5C3}};
  endfunction

  always @(negedge clk) begin
    if (hdr_val && data_val) chk("hdr_data_both", 1, 0);
    if (!rst && p_hv && !p_hr) chk("hdr_hold", {hdr_val, eth_hdr, size}, {1'b1, p_h});
    if (!rst && p_dv && !p_dr) chk("data_hold", {data_val, data}, {1'b1, p_d});
    if (hdr_val && hdr_rdy) begin
      hdrs++;
      if (exp_hdr.size() == 0) chk("hdr_unexpected", {eth_hdr, size}, 0);
      else chk("hdr", {eth_hdr, size}, exp_hdr.pop_front());
    end
    if (data_val && data_rdy) begin
      beats++;
      if (last) last_pad = int'(pad);
      if (exp_beat.size() == 0) chk("beat_unexpected", {data, last, pad}, 0);
      else chk("beat", {data, last, pad}, exp_beat.pop_front());
    end
    p_hv = hdr_val; p_hr = hdr_rdy; p_h = {eth_hdr, size};
    p_dv = data_val; p_dr = data_rdy; p_d = data;
  end

  initial forever begin
    @(posedge clk); #1;
    hdr_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    data_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_flit(input logic [511:0] d);
    int n = 0;
    in_val = 1; in_data = d;
    do begin @(negedge clk); n++; end while (!in_rdy && n < 2000);
    if (!in_rdy) chk("flit_timeout", 0, 1);
    @(posedge clk); #1 in_val = 0;
  endtask

  task automatic send_frame(input int f, input int sz, input int len, input bit good);
    send_flit({8'd3, 8'd5, 8'(len), 488'd0});
    if (len == 0) return;
    send_flit({ehdr(f), 16'(sz), 384'd0});
    if (good) exp_hdr.push_back({ehdr(f), 16'(sz)});
    for (int i = 0; i < len - 1; i++) begin
      if (good) exp_beat.push_back({beat(f, i), i == len - 2, (i == len - 2) ? 6'((64 - sz % 64) % 64) : 6'd0});
      send_flit(beat(f, i));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int h0, b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", in_rdy, 0);
    chk("rst_vals", {hdr_val, data_val, last, pad, err}, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle_rdy", in_rdy, 1);
    @(posedge clk); #1;

    b0 = beats; h0 = hdrs;
    send_frame(1, 100, 3, 1); idle(5);
    chk("f100_pad", last_pad, 28);
    chk("f100_beats", beats - b0, 2);
    chk("f100_hdrs", hdrs - h0, 1);

    b0 = beats; last_pad = -1;
    send_frame(2, 128, 3, 1); idle(5);
    chk("f128_pad", last_pad, 0);
    chk("f128_beats", beats - b0, 2);

    b0 = beats; h0 = hdrs;
    send_frame(3, 0, 1, 1); idle(5);
    chk("f0_hdrs", hdrs - h0, 1);
    chk("f0_beats", beats - b0, 0);

    b0 = beats; h0 = hdrs;
    send_frame(4, 0, 0, 0); idle(5);
    chk("len0_out", {hdrs - h0, beats - b0}, 0);
`ifdef ETH_TX_NOC_IN_CHECK_EN
    chk("len0_err", err, 1);
`else
    chk("len0_err", err, 0);
`endif

`ifdef ETH_TX_NOC_IN_CHECK_EN
    b0 = beats; h0 = hdrs;
    send_frame(5, 100, 4, 0); idle(5);
    chk("bad_out", {hdrs - h0, beats - b0}, 0);
    chk("bad_err", err, 1);
    b0 = beats;
    send_frame(6, 100, 3, 1); idle(5);
    chk("after_bad_beats", beats - b0, 2);
`endif

    stall = 1;
    b0 = beats;
    for (int f = 0; f < 50; f++) begin
      int sz = $urandom_range(0, 300);
      send_frame(100 + f, sz, 1 + (sz + 63) / 64, 1);
    end
    stall = 0; idle(20);
    chk("rand_left", exp_beat.size() + exp_hdr.size(), 0);

    b0 = beats;
    send_flit({8'd3, 8'd5, 8'd4, 488'd0});
    exp_hdr.push_back({ehdr(7), 16'd150});
    send_flit({ehdr(7), 16'd150, 384'd0});
    exp_beat.push_back({beat(7, 0), 1'b0, 6'd0});
    send_flit(beat(7, 0));
    rst = 1;
    @(negedge clk);
    chk("midrst_vals", {hdr_val, data_val, last, pad, in_rdy}, 0);
    idle(2); rst = 0;
    chk("midrst_beats", beats - b0, 1);
    b0 = beats; last_pad = -1;
    send_frame(8, 150, 4, 1); idle(5);
    chk("postrst_beats", beats - b0, 3);
    chk("postrst_pad", last_pad, 42);
    chk("final_left", exp_beat.size() + exp_hdr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
